led_seq_engine: RTL and testbench

- Parametrised LED-bar sequencer for board status displays.
- Generalises the fixed 5-LED bounce/blink FSM to N LEDs, a programmable step rate, four display modes and an optional blank phase between steps.
- Sits between the system clock domain and the LED pads. Driven by a software-writable mode/rate register.

---
 rtl/led_seq_pkg.sv | 20 ++
 rtl/led_tick_gen.sv | 27 ++
 rtl/led_seq_engine.sv | 106 ++++++++++
 tb/tb_led_seq_engine.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// Shared definitions for the LED-bar sequencer: mode encodings, display phase
// and the bar (thermometer) decode used to build LED patterns.
package led_seq_pkg;

    localparam logic [1:0] MODE_BAR_BOUNCE = 2'b00;
    localparam logic [1:0] MODE_DOT_BOUNCE = 2'b01;
    localparam logic [1:0] MODE_BAR_WRAP   = 2'b10;
    localparam logic [1:0] MODE_BLINK      = 2'b11;

    typedef enum logic {
        SHOW  = 1'b0,
        BLANK = 1'b1
    } phase_t;

    // One bit of a thermometer code: LED idx is lit when it lies below lvl.
    function automatic logic therm_bit(input int unsigned lvl, input int unsigned idx);
        return (idx < lvl);
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Step-rate divider: emits a one-clock tick every div+1 enabled clocks and
// freezes completely while enable is low.
module led_tick_gen #(
    parameter int DIV_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;

    assign tick = enable && (cnt == div);

    // Lowering div below cnt lets cnt roll through its full range before matching.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (enable) begin
            if (cnt == div) cnt <= '0;
            else            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/led_seq_engine.sv
// LED-bar sequencer: bounce, dot-bounce, wrap and blink patterns over NUM_LEDS
// outputs, stepped by led_tick_gen, with an optional all-off step in between.
module led_seq_engine
    import led_seq_pkg::*;
#(
    parameter int NUM_LEDS = 5,
    parameter int DIV_W    = 8,
    parameter int LVL_W    = $clog2(NUM_LEDS + 1)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic [1:0]          mode,
    input  logic [DIV_W-1:0]    div,
    input  logic                blank_en,
    output logic [NUM_LEDS-1:0] leds,
    output logic [LVL_W-1:0]    level,
    output logic                dir_up,
    output logic                wrap
);

    localparam logic [LVL_W-1:0] TOP_BAR = LVL_W'(NUM_LEDS);
    localparam logic [LVL_W-1:0] TOP_DOT = LVL_W'(NUM_LEDS - 1);

    logic       tick;
    phase_t     phase;
    logic [1:0] mode_q;
    logic [LVL_W-1:0] top_lvl;

    led_tick_gen #(.DIV_W(DIV_W)) u_tick (
        .clock  (clock),
        .reset  (reset),
        .enable (enable),
        .div    (div),
        .tick   (tick)
    );

    assign top_lvl = (mode_q == MODE_DOT_BOUNCE) ? TOP_DOT : TOP_BAR;

    // Mode reload outranks blanking, which outranks advancing; reload never pulses wrap.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            level  <= '0;
            dir_up <= 1'b1;
            phase  <= SHOW;
            mode_q <= MODE_BAR_BOUNCE;
            wrap   <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (tick) begin
                if (mode != mode_q) begin
                    mode_q <= mode;
                    level  <= '0;
                    dir_up <= 1'b1;
                    phase  <= SHOW;
                end else if (blank_en && (phase == SHOW)) begin
                    phase <= BLANK;
                end else begin
                    phase <= SHOW;
                    case (mode_q)
                        MODE_BAR_BOUNCE, MODE_DOT_BOUNCE: begin
                            if (dir_up) begin
                                level <= level + 1'b1;
                                if (level + 1'b1 == top_lvl) dir_up <= 1'b0;
                            end else begin
                                level <= level - 1'b1;
                                if (level == LVL_W'(1)) begin
                                    dir_up <= 1'b1;
                                    wrap   <= 1'b1;
                                end
                            end
                        end
                        MODE_BAR_WRAP: begin
                            if (level == TOP_BAR) begin
                                level <= '0;
                                wrap  <= 1'b1;
                            end else begin
                                level <= level + 1'b1;
                            end
                        end
                        default: begin
                            if (level == '0) begin
                                level <= TOP_BAR;
                                wrap  <= 1'b1;
                            end else begin
                                level <= '0;
                            end
                        end
                    endcase
                end
            end
        end
    end

    // Pattern depends only on registered state, so inputs never reach the pads directly.
    always_comb begin
        leds = '0;
        if (phase == SHOW) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                if (mode_q == MODE_DOT_BOUNCE) leds[i] = (level == LVL_W'(i));
                else                           leds[i] = therm_bit(32'(level), 32'(i));
            end
        end
    end

endmodule

// File: tb/tb_led_seq_engine.sv
// Directed bench for led_seq_engine with NUM_LEDS=4: each mode, blanking,
// freeze with pending mode change, and asynchronous reset mid-sweep.
module tb_led_seq_engine;

    localparam int NUM_LEDS = 4;
    localparam int DIV_W    = 8;
    localparam int LVL_W    = $clog2(NUM_LEDS + 1);

    logic                clock;
    logic                reset;
    logic                enable;
    logic [1:0]          mode;
    logic [DIV_W-1:0]    div;
    logic                blank_en;
    logic [NUM_LEDS-1:0] leds;
    logic [LVL_W-1:0]    level;
    logic                dir_up;
    logic                wrap;

    int total_cnt = 0;
    int bad_cnt   = 0;

    led_seq_engine #(.NUM_LEDS(NUM_LEDS), .DIV_W(DIV_W)) dut (
        .clock    (clock),
        .reset    (reset),
        .enable   (enable),
        .mode     (mode),
        .div      (div),
        .blank_en (blank_en),
        .leds     (leds),
        .level    (level),
        .dir_up   (dir_up),
        .wrap     (wrap)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clocks(input int n);
        for (int i = 0; i < n; i++) @(negedge clock);
    endtask

    logic [3:0] bb_leds [8] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b0000};
    logic       bb_dir  [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [3:0] db_leds [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001};
    logic       db_dir  [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [3:0] bw_leds [11] = '{4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0011, 4'b0000,
                                 4'b0111, 4'b0000, 4'b1111, 4'b0000, 4'b0000};
    logic [3:0] bl_leds [4] = '{4'b0000, 4'b1111, 4'b0000, 4'b1111};
    logic       bl_wrap [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        logic [3:0] prev_leds;

        reset    = 1'b0;
        enable   = 1'b0;
        mode     = 2'b00;
        div      = '0;
        blank_en = 1'b0;
        wait_clocks(2);
        check_eq("rst_leds", 32'(leds), 32'h0);
        check_eq("rst_level", 32'(level), 32'h0);
        check_eq("rst_dir", 32'(dir_up), 32'h1);
        check_eq("rst_wrap", 32'(wrap), 32'h0);

        // BAR_BOUNCE, one step per clock
        reset  = 1'b1;
        enable = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            check_eq($sformatf("bb_leds%0d", k), 32'(leds), 32'(bb_leds[k]));
            check_eq($sformatf("bb_dir%0d", k), 32'(dir_up), 32'(bb_dir[k]));
            check_eq($sformatf("bb_wrap%0d", k), 32'(wrap), (k == 7) ? 32'h1 : 32'h0);
        end

        // DOT_BOUNCE: first tick reloads the mode
        mode = 2'b01;
        for (int k = 0; k < 7; k++) begin
            @(negedge clock);
            check_eq($sformatf("db_leds%0d", k), 32'(leds), 32'(db_leds[k]));
            check_eq($sformatf("db_dir%0d", k), 32'(dir_up), 32'(db_dir[k]));
            check_eq($sformatf("db_wrap%0d", k), 32'(wrap), (k == 6) ? 32'h1 : 32'h0);
        end

        // BAR_WRAP with blank steps, tick every 3 clocks
        mode      = 2'b10;
        div       = 8'd2;
        blank_en  = 1'b1;
        prev_leds = leds;
        for (int t = 0; t < 11; t++) begin
            for (int c = 0; c < 3; c++) begin
                @(negedge clock);
                if (c < 2) begin
                    check_eq($sformatf("bw_hold%0d_%0d", t, c), 32'(leds), 32'(prev_leds));
                    check_eq($sformatf("bw_nowrap%0d_%0d", t, c), 32'(wrap), 32'h0);
                end else begin
                    check_eq($sformatf("bw_leds%0d", t), 32'(leds), 32'(bw_leds[t]));
                    check_eq($sformatf("bw_wrap%0d", t), 32'(wrap), (t == 10) ? 32'h1 : 32'h0);
                end
            end
            prev_leds = bw_leds[t];
        end

        // BLINK, tick every 2 clocks
        mode     = 2'b11;
        div      = 8'd1;
        blank_en = 1'b0;
        for (int t = 0; t < 4; t++) begin
            wait_clocks(2);
            check_eq($sformatf("bl_leds%0d", t), 32'(leds), 32'(bl_leds[t]));
            check_eq($sformatf("bl_wrap%0d", t), 32'(wrap), 32'(bl_wrap[t]));
        end

        // Freeze with a pending mode change
        mode = 2'b00;
        div  = 8'd0;
        wait_clocks(4);
        check_eq("frz_pre_level", 32'(level), 32'h3);
        check_eq("frz_pre_dir", 32'(dir_up), 32'h1);
        mode   = 2'b01;
        enable = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            check_eq($sformatf("frz_leds%0d", c), 32'(leds), 32'h7);
            check_eq($sformatf("frz_level%0d", c), 32'(level), 32'h3);
        end
        enable = 1'b1;
        @(negedge clock);
        check_eq("frz_post_level", 32'(level), 32'h0);
        check_eq("frz_post_leds", 32'(leds), 32'h1);
        check_eq("frz_post_dir", 32'(dir_up), 32'h1);
        check_eq("frz_post_wrap", 32'(wrap), 32'h0);

        // Asynchronous reset mid-sweep
        mode = 2'b00;
        wait_clocks(3);
        check_eq("ar_pre_level", 32'(level), 32'h2);
        div = 8'd3;
        #2 reset = 1'b0;
        #1;
        check_eq("ar_leds", 32'(leds), 32'h0);
        check_eq("ar_level", 32'(level), 32'h0);
        check_eq("ar_dir", 32'(dir_up), 32'h1);
        @(negedge clock);
        reset = 1'b1;
        wait_clocks(3);
        check_eq("ar_wait_level", 32'(level), 32'h0);
        @(negedge clock);
        check_eq("ar_first_level", 32'(level), 32'h1);
        check_eq("ar_first_leds", 32'(leds), 32'h1);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
